// File: rtl/tcp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tcp_pkg
//  Brief    : Shared types and helpers for the TCP receive payload buffer.
//             Write/read FSM state encodings, bytes-per-word constant and
//             the byte-length to word-count helper.
//  Revision : 1.0 - initial release
// ============================================================================
package tcp_pkg;

  localparam int TCP_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

  // Number of 32-bit words needed to carry len bytes: ceil(len/4)
  function automatic logic [15:0] word_count(input logic [15:0] len);
    logic [16:0] sum;
    sum = {1'b0, len} + 17'(TCP_WORD_BYTES - 1);
    return 16'(sum >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcp_len_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tcp_len_fifo
//  Brief    : SEG_DEPTH x 16 synchronous FIFO holding committed segment
//             byte lengths. Push when full and pop when empty are ignored.
//             dout shows the head entry combinationally. SEG_DEPTH must be
//             a power of 2 and at least 2.
//  Revision : 1.0 - initial release
// ============================================================================
module tcp_len_fifo #(
  parameter int SEG_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        pop,
  output logic [15:0] dout,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(SEG_DEPTH);

  logic [15:0] mem [SEG_DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp[AW-1:0]] <= din;
    end
  end

  // Read/write pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/tcp_rx_payload_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tcp_rx_payload_buffer
//  Brief    : Circular payload buffer behind the TCP decoder. Payload words
//             are written tentatively and either committed (good segment)
//             or rolled back (bad checksum, length mismatch, length FIFO
//             full, overflow, or abort by a new start). The application
//             reads whole committed segments word by word.
//             Optional macro TCP_RX_STATS_EN adds saturating commit/drop
//             counters seg_ok_cnt and seg_drop_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module tcp_rx_payload_buffer
  import tcp_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int SEG_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        wr_en,
  input  logic [31:0] data_tcp,
  input  logic [15:0] len_data,
  input  logic        fin,
  input  logic        ok,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        seg_avail,
  output logic [15:0] seg_len,
  output logic        full
`ifdef TCP_RX_STATS_EN
  ,
  output logic [15:0] seg_ok_cnt,
  output logic [15:0] seg_drop_cnt
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_c;
  logic [PTR_W-1:0] wr_ptr_t;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] used_words;
  logic [PTR_W-1:0] free_words;
  logic             has_room;
  logic [15:0]      wc;
  logic [15:0]      wc_total;
  wr_state_t        wr_state;
  rd_state_t        rd_state;
  logic [15:0]      rem;
  logic [15:0]      head_words;
  logic             wr_fire;
  logic             commit_ok;
  logic             rd_go;
  logic             rd_is_last;
  logic             lf_pop;
  logic [15:0]      lf_dout;
  logic             lf_empty;
  logic             lf_full;

  // Space accounting covers committed plus tentative words
  assign used_words = wr_ptr_t - rd_ptr;
  assign free_words = PTR_W'(DEPTH) - used_words;
  assign has_room   = (free_words != '0);
  assign full       = !has_room;

  // A start always wins over data/fin arriving in the same cycle
  assign wr_fire  = (wr_state == RECV) && !start && wr_en && has_room;
  assign wc_total = wc + 16'(wr_fire);

  // Commit needs a clean, exactly sized, non-empty segment and a free length slot;
  // an overflowing word on the fin cycle also spoils the segment
  assign commit_ok = (wr_state == RECV) && !start && fin && ok &&
                     (len_data != 16'd0) &&
                     (wc_total == word_count(len_data)) &&
                     !lf_full && !(wr_en && !has_room);

  // Payload storage, indexed by the low pointer bits
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_t[ADDR_W-1:0]] <= data_tcp;
    end
  end

  // Write FSM: tentative fill, then commit or roll back to wr_ptr_c
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= IDLE;
      wr_ptr_c <= '0;
      wr_ptr_t <= '0;
      wc       <= '0;
    end else begin
      case (wr_state)
        IDLE: begin
          if (start) begin
            wr_ptr_t <= wr_ptr_c;
            wc       <= '0;
            wr_state <= RECV;
          end
        end
        RECV: begin
          if (start) begin
            wr_ptr_t <= wr_ptr_c;
            wc       <= '0;
          end else if (fin) begin
            if (commit_ok) begin
              wr_ptr_c <= wr_ptr_t + PTR_W'(wr_fire);
              wr_ptr_t <= wr_ptr_t + PTR_W'(wr_fire);
            end else begin
              wr_ptr_t <= wr_ptr_c;
            end
            wr_state <= IDLE;
          end else if (wr_en) begin
            if (has_room) begin
              wr_ptr_t <= wr_ptr_t + 1'b1;
              wc       <= wc + 16'd1;
            end else begin
              wr_ptr_t <= wr_ptr_c;
              wr_state <= DROP;
            end
          end
        end
        DROP: begin
          if (start) begin
            wr_ptr_t <= wr_ptr_c;
            wc       <= '0;
            wr_state <= RECV;
          end else if (fin) begin
            wr_state <= IDLE;
          end
        end
        default: wr_state <= IDLE;
      endcase
    end
  end

  // Read side: only committed segments are visible through the length FIFO
  assign head_words = word_count(lf_dout);
  assign rd_go      = rd_en && seg_avail;
  assign rd_is_last = (rd_state == RD_IDLE) ? (head_words == 16'd1) : (rem == 16'd1);
  assign lf_pop     = rd_go && rd_is_last;

  // Read FSM: one registered word per accepted rd_en, segment length drives rd_last
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rd_ptr   <= '0;
      rem      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      rd_last  <= rd_go && rd_is_last;
      if (rd_go) begin
        rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
        if (rd_is_last) begin
          rd_state <= RD_IDLE;
        end else begin
          rd_state <= RD_BURST;
          rem      <= ((rd_state == RD_IDLE) ? head_words : rem) - 16'd1;
        end
      end
    end
  end

  tcp_len_fifo #(
    .SEG_DEPTH (SEG_DEPTH)
  ) u_len_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (commit_ok),
    .din   (len_data),
    .pop   (lf_pop),
    .dout  (lf_dout),
    .empty (lf_empty),
    .full  (lf_full)
  );

  assign seg_avail = !lf_empty;
  assign seg_len   = lf_empty ? 16'd0 : lf_dout;

`ifdef TCP_RX_STATS_EN
  logic abort_evt;
  logic fin_drop_evt;

  // Abort by start, or a rollback at fin that is not a pure ACK
  assign abort_evt    = start && (wr_state != IDLE);
  assign fin_drop_evt = fin && !start &&
                        (((wr_state == RECV) && !commit_ok && !(ok && (len_data == 16'd0))) ||
                         (wr_state == DROP));

  // Saturating commit and drop counters
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_ok_cnt   <= '0;
      seg_drop_cnt <= '0;
    end else begin
      if (commit_ok && (seg_ok_cnt != 16'hFFFF)) begin
        seg_ok_cnt <= seg_ok_cnt + 16'd1;
      end
      if ((abort_evt || fin_drop_evt) && (seg_drop_cnt != 16'hFFFF)) begin
        seg_drop_cnt <= seg_drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
